// File: rtl/cache_pkg.sv
// Shared address split and refill FSM state encoding for the direct-mapped cache.
// The lookup stage imports this package too, so the address split is defined once.
package cache_pkg;

   localparam int B_OFFSET = 2;
   localparam int L_OFFSET = 8;
   localparam int T_OFFSET = 32 - 2 - B_OFFSET - L_OFFSET;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      DONE
   } state_t;

   function automatic logic [T_OFFSET-1:0] get_tag(input logic [31:0] a);
      return a[31 -: T_OFFSET];
   endfunction

   function automatic logic [L_OFFSET-1:0] get_index(input logic [31:0] a);
      return a[2+B_OFFSET +: L_OFFSET];
   endfunction

   function automatic logic [B_OFFSET-1:0] get_word(input logic [31:0] a);
      return a[2 +: B_OFFSET];
   endfunction

   // Clears the byte and word bits so the request starts at word 0 of the line.
   function automatic logic [31:0] line_addr(input logic [31:0] a, input int b);
      return a & ~((32'd1 << (2 + b)) - 32'd1);
   endfunction

endpackage

// File: rtl/cache_refill.sv
// Miss refill engine: issues one line read, streams beats into the data array,
// then sets tag/valid on the last beat and pulses done.
module cache_refill
   import cache_pkg::*;
#(
   parameter int b_offset = B_OFFSET,
   parameter int l_offset = L_OFFSET,
   localparam int t_offset = 32 - 2 - b_offset - l_offset
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_valid,
   output logic                miss_ready,
   input  logic [31:0]         miss_addr,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [31:0]         mem_req_addr,
   input  logic                mem_rsp_valid,
   input  logic [31:0]         mem_rsp_data,
   output logic                fill_we,
   output logic [l_offset-1:0] fill_index,
   output logic [b_offset-1:0] fill_word,
   output logic [31:0]         fill_data,
   output logic [t_offset-1:0] fill_tag,
   output logic                fill_inval,
   output logic                fill_valid_set,
   output logic                busy,
   output logic                done
);

   localparam logic [b_offset-1:0] LAST_BEAT = '1;

   state_t              state;
   logic [b_offset-1:0] cnt;
   logic [31:0]         lat_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_addr      <= '0;
         miss_ready    <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         mem_req_valid <= 1'b0;
         fill_inval    <= 1'b0;
      end else begin
         fill_inval <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_valid && miss_ready) begin
                  lat_addr      <= miss_addr;
                  state         <= REQ;
                  miss_ready    <= 1'b0;
                  busy          <= 1'b1;
                  mem_req_valid <= 1'b1;
                  // Invalidate up front so an aborted refill never leaves a stale-valid line.
                  fill_inval    <= 1'b1;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state         <= FILL;
                  mem_req_valid <= 1'b0;
                  cnt           <= '0;
               end
            end
            FILL: begin
               if (mem_rsp_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               miss_ready <= 1'b1;
               busy       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Beats pass straight through to the write port in the cycle they arrive.
   always_comb begin
      fill_we        = (state == FILL) && mem_rsp_valid;
      fill_valid_set = fill_we && (cnt == LAST_BEAT);
      fill_word      = fill_we ? cnt : '0;
      fill_data      = fill_we ? mem_rsp_data : '0;
      fill_tag       = fill_valid_set ? lat_addr[31 -: t_offset] : '0;
      fill_index     = (fill_we || fill_inval) ? lat_addr[2+b_offset +: l_offset] : '0;
      mem_req_addr   = mem_req_valid ? line_addr(lat_addr, b_offset) : '0;
   end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: expected fill writes are queued as beats are
// driven and checked by a monitor as the write port fires.
module tb_cache_refill;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [31:0] miss_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        fill_we;
   logic [7:0]  fill_index;
   logic [1:0]  fill_word;
   logic [31:0] fill_data;
   logic [19:0] fill_tag;
   logic        fill_inval;
   logic        fill_valid_set;
   logic        busy;
   logic        done;

   typedef struct {
      logic [7:0]  idx;
      logic [1:0]  word;
      logic [31:0] data;
      logic        vs;
      logic [19:0] tag;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   we_cnt = 0;

   cache_refill dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .fill_we(fill_we), .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
      .fill_tag(fill_tag), .fill_inval(fill_inval), .fill_valid_set(fill_valid_set),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] idx, input int w, input logic [31:0] d, input logic [19:0] tg);
      exp_t e;
      e.idx  = idx;
      e.word = w[1:0];
      e.data = d;
      e.vs   = (w == 3);
      e.tag  = (w == 3) ? tg : 20'h0;
      q.push_back(e);
   endtask

   // Drives a beat-valid pattern (bit 0 first), then expects done the cycle after the 4th beat.
   task automatic beats(input logic [7:0] idx, input logic [19:0] tg, input logic [31:0] base,
                        input int len, input logic [15:0] pat);
      int w = 0;
      for (int i = 0; i < len; i++) begin
         step();
         mem_rsp_valid = pat[i];
         mem_rsp_data  = base + w;
         if (pat[i]) begin
            push(idx, w, base + w, tg);
            w++;
         end
         smp();
         check("fill_we_pattern", fill_we, pat[i]);
         check("miss_ready_fill", miss_ready, 0);
      end
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      smp();
      check("done_pulse", done, 1);
      check("miss_ready_done", miss_ready, 0);
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (fill_we) begin
         we_cnt++;
         if (q.size() == 0) check("unexpected_fill_we", fill_we, 0);
         else begin
            mon_e = q.pop_front();
            check("fill_index", fill_index, mon_e.idx);
            check("fill_word", fill_word, mon_e.word);
            check("fill_data", fill_data, mon_e.data);
            check("fill_valid_set", fill_valid_set, mon_e.vs);
            check("fill_tag", fill_tag, mon_e.tag);
         end
      end else begin
         check("valid_set_without_we", fill_valid_set, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      step(); step(); smp();
      check("rst_miss_ready", miss_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_addr", mem_req_addr, 0);
      check("rst_inval", fill_inval, 0);

      // Basic refill, ready immediately, back-to-back beats
      step();
      rst = 1'b0; miss_valid = 1'b1; miss_addr = 32'h12345678; mem_req_ready = 1'b1;
      smp();
      check("t1_miss_ready_idle", miss_ready, 1);
      step();
      miss_valid = 1'b0;
      smp();
      check("t1_req_valid", mem_req_valid, 1);
      check("t1_req_addr", mem_req_addr, 32'h12345670);
      check("t1_inval", fill_inval, 1);
      check("t1_inval_index", fill_index, 8'h67);
      check("t1_busy", busy, 1);
      check("t1_miss_ready_req", miss_ready, 0);
      beats(8'h67, 20'h12345, 32'hA0, 4, 16'b1111);
      step(); smp();
      check("t1_miss_ready_back", miss_ready, 1);
      check("t1_busy_clear", busy, 0);
      check("t1_done_once", done, 0);

      // Stalled request with spurious responses, then gapped beats
      step();
      miss_valid = 1'b1; miss_addr = 32'h0000ABC4; mem_req_ready = 1'b0;
      smp();
      for (int k = 1; k <= 5; k++) begin
         step();
         miss_valid = 1'b0;
         mem_rsp_valid = (k == 3 || k == 4);
         mem_rsp_data = 32'hDEAD0000 + k;
         smp();
         check("t2_req_valid_stall", mem_req_valid, 1);
         check("t2_req_addr_stall", mem_req_addr, 32'h0000ABC0);
         check("t2_inval_once", fill_inval, (k == 1));
         check("t2_no_we_in_req", fill_we, 0);
         if (k == 1) check("t2_inval_index", fill_index, 8'hBC);
      end
      step();
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
      smp();
      check("t2_req_accept", mem_req_valid, 1);
      beats(8'hBC, 20'h0000A, 32'hB0, 7, 16'b1011001);
      step(); smp();
      check("t2_idle", miss_ready, 1);

      // miss_valid held through a refill; second miss taken in first IDLE cycle
      step();
      miss_valid = 1'b1; miss_addr = 32'h00005550;
      smp();
      step();
      miss_addr = 32'h00000010;
      smp();
      check("t4_miss_ready_req", miss_ready, 0);
      check("t4_req_addr", mem_req_addr, 32'h00005550);
      beats(8'h55, 20'h00005, 32'hC0, 4, 16'b1111);
      step(); smp();
      check("t4_idle_accept", miss_ready, 1);
      step();
      miss_valid = 1'b0;
      smp();
      check("t4_second_req_addr", mem_req_addr, 32'h00000010);
      check("t4_second_index", fill_index, 8'h01);
      check("t4_second_inval", fill_inval, 1);
      beats(8'h01, 20'h00000, 32'hD0, 4, 16'b1111);
      step(); smp();

      // Reset after the second beat, then stray responses in IDLE
      step();
      miss_valid = 1'b1; miss_addr = 32'hFFFFFFFC;
      smp();
      step();
      miss_valid = 1'b0;
      smp();
      check("t5_req_addr", mem_req_addr, 32'hFFFFFFF0);
      check("t5_inval_index", fill_index, 8'hFF);
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hE0;
      push(8'hFF, 0, 32'hE0, 20'hFFFFF);
      smp();
      step();
      mem_rsp_data = 32'hE1;
      push(8'hFF, 1, 32'hE1, 20'hFFFFF);
      smp();
      step();
      rst = 1'b1; mem_rsp_valid = 1'b0;
      smp();
      step();
      rst = 1'b0;
      smp();
      check("t5_busy", busy, 0);
      check("t5_miss_ready", miss_ready, 1);
      check("t5_no_done", done, 0);
      check("t5_req_valid", mem_req_valid, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         mem_rsp_valid = 1'b1; mem_rsp_data = 32'hF0 + k;
         smp();
         check("t5_stray_we", fill_we, 0);
         check("t5_stray_vs", fill_valid_set, 0);
         check("t5_stray_done", done, 0);
      end
      step();
      mem_rsp_valid = 1'b0;
      smp();

      check("queue_drained", q.size(), 0);
      check("done_count", done_cnt, 4);
      check("fill_we_count", we_cnt, 18);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_refill.md
Name: cache_refill

Overview:
- Miss-handling stage directly downstream of the direct-mapped cache lookup.
- Takes one miss address at a time and issues a line-aligned read to the memory bus.
- Collects 2**b_offset word beats in order and writes each beat into the cache data array through a write port, together with the tag and valid-bit updates.
- Pulses done when the line is resident.

Parameters:
- b_offset, 2, log2 of words per line (4 words of 32 bits).
- l_offset, 8, index bits (256 lines).
- t_offset, 32-2-b_offset-l_offset (derived localparam, 20 by default), tag bits.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  miss request from lookup stage.
- miss_ready  out  1  high only in IDLE.
- miss_addr  in  32  byte address of the missing access.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  line-aligned address (low 2+b_offset bits zero).
- mem_rsp_valid  in  1  one data beat present.
- mem_rsp_data  in  32  beat data, word 0 first.
- fill_we  out  1  write fill_data into the data array.
- fill_index  out  l_offset  line index being filled.
- fill_word  out  b_offset  word within line.
- fill_data  out  32  word to write.
- fill_tag  out  t_offset  tag to write with final beat.
- fill_inval  out  1  clear valid bit of fill_index.
- fill_valid_set  out  1  set valid bit and write fill_tag.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Address split: byte = addr[1:0], word = addr[2+b_offset-1:2], index = next l_offset bits, tag = top t_offset bits.
- Reset: state IDLE; beat counter 0; miss_ready=1; all other outputs 0; the latched address register is cleared to 0.
- States are IDLE, REQ, FILL and DONE.
- IDLE:
  - miss_ready=1.
  - On miss_valid&miss_ready, latch miss_addr and go to REQ.
  - mem_rsp_valid in IDLE is ignored.
- REQ:
  - mem_req_valid=1 with mem_req_addr = {latched tag, index, zeros}.
  - The address is held stable until mem_req_ready.
  - fill_inval=1 in the first REQ cycle only, so an aborted refill never leaves a stale-valid line.
  - On mem_req_valid&mem_req_ready, go to FILL with counter=0.
  - mem_rsp_valid in REQ is ignored: memory must not respond before acceptance.
- FILL:
  - Each cycle with mem_rsp_valid: fill_we=1, fill_word=counter, fill_data=mem_rsp_data, fill_index=latched index (combinational pass-through, zero added latency), then counter increments.
  - Gaps (mem_rsp_valid=0) produce no write.
  - On the beat where counter==2**b_offset-1: fill_valid_set=1 and fill_tag=latched tag in the same cycle; the counter wraps to 0 and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. miss_ready stays 0 in DONE, so no miss is accepted in the completion cycle.
- Outputs when not asserted: fill_* and mem_req_addr are driven 0 whenever their strobe is low.
- Latency with mem_req_ready=1 and back-to-back beats:
  - Miss accepted at cycle 0.
  - Request issued at cycle 1.
  - Beats at cycles 2..5.
  - done at cycle 6.
  - miss_ready high again at cycle 7.
- rst asserted mid-operation (any state): return to IDLE next edge with reset values. Any in-flight memory response after reset is ignored in IDLE. The line stays invalid if fill_inval was already issued.
- Only one outstanding refill at a time; no critical-word-first, no write-back (read-only cache).

Decomposition:
- Package cache_pkg holds:
  - default values of b_offset/l_offset;
  - the state enum (IDLE, REQ, FILL, DONE);
  - functions get_tag/get_index/get_word/line_addr over a 32-bit address.
- No sub-module: FSM plus beat counter fit in one module.
- The lookup stage and this block both import cache_pkg so the address split is defined once.

Test Plan:
- miss_addr=0x12345678, mem_req_ready=1, beats 0xA0..0xA3 back-to-back, all at default parameters:
  - fill_inval at cycle 1 with fill_index=0x67;
  - mem_req_addr=0x12345670;
  - fill_word 0..3 with data 0xA0..0xA3;
  - fill_valid_set with fill_tag=0x12345 on beat 3;
  - done at cycle 6.
- mem_req_ready held 0 for 5 cycles: mem_req_valid and mem_req_addr stay stable; fill_inval pulses only once; the request completes on the first ready cycle.
- Beats with gaps (valid pattern 1,0,0,1,1,0,1): exactly 4 fill_we pulses with word 0..3 in order; done one cycle after the 4th beat.
- miss_valid held high during a refill: miss_ready=0 in REQ/FILL/DONE. A second miss at 0x00000010 is accepted in the first IDLE cycle, giving fill_index=0x01 and mem_req_addr=0x00000010.
- rst pulsed after the 2nd beat: next cycle IDLE, busy=0, no done. Stray mem_rsp_valid then produces no fill_we and no fill_valid_set.
- Spurious mem_rsp_valid in IDLE and in REQ before acceptance: no fill_we, counter unchanged.
